// File: rtl/ads131_miso_frame_receiver_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ads131_pkg                                                       |
// | Brief   : Shared constants, state encodings and CRC step for the ADS131    |
// |           MISO frame receiver.                                             |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
package ads131_pkg;

    localparam int WORD_BITS  = 32;
    localparam int DATA_BITS  = 24;
    localparam int NUM_CH     = 4;
    localparam int STATUS_IDX = 0;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    typedef logic [15:0] crc_t;

    // One MSB-first CRC-16-CCITT step for a single incoming bit.
    function automatic crc_t crc16_step(input crc_t crc, input logic b);
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? CRC_POLY : 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ads131_miso_frame_receiver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ads131_miso_frame_receiver_if                                    |
// | Brief   : SPI receive inputs and frame result outputs of the receiver.     |
// |           ADS131_RX_CRC_EN adds the crc_error strobe.                      |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ads131_miso_frame_receiver_if #(
    parameter int NUM_CH    = ads131_pkg::NUM_CH,
    parameter int WORD_BITS = ads131_pkg::WORD_BITS,
    parameter int DATA_BITS = ads131_pkg::DATA_BITS
);
    logic                        spi_cs_n;
    logic                        spi_sclk;
    logic                        spi_miso;
    logic                        adc_init_done;
    logic [WORD_BITS-1:0]        status_word;
    logic [NUM_CH*DATA_BITS-1:0] ch_data;
    logic                        frame_valid;
    logic                        frame_error;
    logic [15:0]                 frame_count;
`ifdef ADS131_RX_CRC_EN
    logic                        crc_error;

    modport master (
        output spi_cs_n, spi_sclk, spi_miso, adc_init_done,
        input  status_word, ch_data, frame_valid, frame_error, frame_count, crc_error
    );
    modport slave (
        input  spi_cs_n, spi_sclk, spi_miso, adc_init_done,
        output status_word, ch_data, frame_valid, frame_error, frame_count, crc_error
    );
`else
    modport master (
        output spi_cs_n, spi_sclk, spi_miso, adc_init_done,
        input  status_word, ch_data, frame_valid, frame_error, frame_count
    );
    modport slave (
        input  spi_cs_n, spi_sclk, spi_miso, adc_init_done,
        output status_word, ch_data, frame_valid, frame_error, frame_count
    );
`endif
endinterface
`default_nettype wire

// File: rtl/ads131_miso_frame_receiver_crc16_ccitt_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : crc16_ccitt_serial                                               |
// | Brief   : Bit-serial CRC-16-CCITT accumulator, MSB first, clearable.       |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module crc16_ccitt_serial
    import ads131_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        clr,
    input  wire logic        bit_en,
    input  wire logic        bit_in,
    output logic      [15:0] crc
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC_INIT;
        end else if (clr) begin
            crc <= CRC_INIT;
        end else if (bit_en) begin
            crc <= crc16_step(crc, bit_in);
        end
    end
endmodule
`default_nettype wire

// File: rtl/ads131_miso_frame_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ads131_miso_frame_receiver                                       |
// | Brief   : Deserialises ADS131A0x MISO words and strobes registered frames. |
// |           ADS131_RX_CRC_EN enables the trailing CRC word check.            |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module ads131_miso_frame_receiver #(
    parameter int NUM_CH    = ads131_pkg::NUM_CH,
    parameter int WORD_BITS = ads131_pkg::WORD_BITS,
    parameter int DATA_BITS = ads131_pkg::DATA_BITS
) (
    input  wire logic                   input_clock,
    input  wire logic                   reset_n,
    ads131_miso_frame_receiver_if.slave bus
);
    import ads131_pkg::*;

`ifdef ADS131_RX_CRC_EN
    localparam int CRC_WORDS = 1;
`else
    localparam int CRC_WORDS = 0;
`endif
    localparam int MAX_WORDS = 1 + NUM_CH + CRC_WORDS;
    localparam int BIT_W     = $clog2(WORD_BITS);
    localparam int IDX_W     = $clog2(MAX_WORDS + 1);

    logic                        r_sclk_q, r_miso_q, r_cs_q, r_cs_pend;
    logic [1:0]                  r_state;
    logic [WORD_BITS-2:0]        r_shift;
    logic [BIT_W-1:0]            r_bit_cnt;
    logic [IDX_W-1:0]            r_word_idx;
    logic                        r_init, r_overrun;
    logic [WORD_BITS-1:0]        r_stat_slot;
    logic [DATA_BITS-1:0]        r_ch_slot [NUM_CH];
    logic [WORD_BITS-1:0]        r_status;
    logic [NUM_CH*DATA_BITS-1:0] r_ch_data;
    logic                        r_fv, r_fe;
    logic [15:0]                 r_count;

    logic                        w_fall, w_cs_fall, w_cs_rise, w_word_done, w_len_ok, w_crc_ok;
    logic                        w_start;
    logic [WORD_BITS-1:0]        w_word;
    logic [IDX_W-1:0]            w_exp_words;

    assign w_fall      = r_sclk_q & ~bus.spi_sclk;
    assign w_cs_fall   = r_cs_q & ~bus.spi_cs_n;
    assign w_cs_rise   = ~r_cs_q & bus.spi_cs_n;
    assign w_start     = (r_state == ST_IDLE) && (w_cs_fall || r_cs_pend);
    assign w_word      = {r_shift, r_miso_q};
    assign w_word_done = w_fall && (r_bit_cnt == BIT_W'(WORD_BITS - 1));
    assign w_exp_words = r_init ? IDX_W'(1 + NUM_CH + CRC_WORDS) : IDX_W'(1 + CRC_WORDS);
    assign w_len_ok    = (r_word_idx == w_exp_words) && (r_bit_cnt == '0) && !r_overrun;

`ifdef ADS131_RX_CRC_EN
    logic [15:0] w_crc;
    logic [15:0] r_crc_slot;
    logic        r_crc_err;

    // Only payload bits feed the CRC; the trailing CRC word itself is excluded.
    crc16_ccitt_serial u_crc (
        .clk    (input_clock),
        .rst_n  (reset_n),
        .clr    (w_start),
        .bit_en ((r_state == ST_SHIFT) && w_fall && (r_word_idx < w_exp_words - 1'b1)),
        .bit_in (r_miso_q),
        .crc    (w_crc)
    );
    assign w_crc_ok      = (r_crc_slot == w_crc);
    assign bus.crc_error = r_crc_err;
`else
    assign w_crc_ok = 1'b1;
`endif

    always_ff @(posedge input_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_q    <= 1'b0;
            r_miso_q    <= 1'b0;
            // Cleared so that a CS already low when reset releases is not taken as a frame start.
            r_cs_q      <= 1'b0;
            r_cs_pend   <= 1'b0;
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_word_idx  <= '0;
            r_init      <= 1'b0;
            r_overrun   <= 1'b0;
            r_stat_slot <= '0;
            for (int i = 0; i < NUM_CH; i++) r_ch_slot[i] <= '0;
            r_status    <= '0;
            r_ch_data   <= '0;
            r_fv        <= 1'b0;
            r_fe        <= 1'b0;
            r_count     <= '0;
`ifdef ADS131_RX_CRC_EN
            r_crc_slot  <= '0;
            r_crc_err   <= 1'b0;
`endif
        end else begin
            r_sclk_q <= bus.spi_sclk;
            r_miso_q <= bus.spi_miso;
            r_cs_q   <= bus.spi_cs_n;
            r_fv     <= 1'b0;
            r_fe     <= 1'b0;
`ifdef ADS131_RX_CRC_EN
            r_crc_err <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    r_cs_pend <= 1'b0;
                    if (w_start) begin
                        r_bit_cnt  <= '0;
                        r_word_idx <= '0;
                        r_overrun  <= 1'b0;
                        r_init     <= bus.adc_init_done;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_fall) begin
                        r_shift   <= w_word[WORD_BITS-2:0];
                        r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + 1'b1;
                        if (w_word_done) begin
                            if (r_word_idx < w_exp_words) begin
                                r_word_idx <= r_word_idx + 1'b1;
                                if (r_word_idx == IDX_W'(STATUS_IDX)) r_stat_slot <= w_word;
                                for (int i = 0; i < NUM_CH; i++) begin
                                    if (r_word_idx == IDX_W'(i + 1))
                                        r_ch_slot[i] <= w_word[WORD_BITS-1 -: DATA_BITS];
                                end
`ifdef ADS131_RX_CRC_EN
                                if (r_word_idx == w_exp_words - 1'b1)
                                    r_crc_slot <= w_word[WORD_BITS-1 -: 16];
`endif
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end
                    end
                    if (w_cs_rise) r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    r_cs_pend <= w_cs_fall;
                    r_state   <= ST_IDLE;
                    if (w_len_ok && w_crc_ok) begin
                        r_status <= r_stat_slot;
                        if (r_init) begin
                            for (int i = 0; i < NUM_CH; i++)
                                r_ch_data[i*DATA_BITS +: DATA_BITS] <= r_ch_slot[i];
                        end
                        r_fv    <= 1'b1;
                        r_count <= r_count + 16'd1;
                    end else if (!w_len_ok) begin
                        r_fe <= 1'b1;
                    end
`ifdef ADS131_RX_CRC_EN
                    else begin
                        r_crc_err <= 1'b1;
                    end
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.status_word = r_status;
    assign bus.ch_data     = r_ch_data;
    assign bus.frame_valid = r_fv;
    assign bus.frame_error = r_fe;
    assign bus.frame_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_ads131_miso_frame_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ads131_miso_frame_receiver                                    |
// | Brief   : Directed self-checking bench for the ADS131 MISO frame receiver. |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ads131_miso_frame_receiver;

    logic clk = 1'b0;
    logic reset_n;
    always #10 clk = ~clk;

    ads131_miso_frame_receiver_if bus ();

    ads131_miso_frame_receiver dut (
        .input_clock (clk),
        .reset_n     (reset_n),
        .bus         (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_fv = 0, n_fe = 0, n_ce = 0;
    int s_fv, s_fe, s_ce;
    logic [31:0] fw [8];
    int nw;

    always @(posedge clk) begin
        if (bus.frame_valid === 1'b1) n_fv <= n_fv + 1;
        if (bus.frame_error === 1'b1) n_fe <= n_fe + 1;
`ifdef ADS131_RX_CRC_EN
        if (bus.crc_error === 1'b1) n_ce <= n_ce + 1;
`endif
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

`ifdef ADS131_RX_CRC_EN
    function automatic logic [15:0] crc_over(input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++)
            for (int j = 31; j >= 0; j--)
                c = {c[14:0], 1'b0} ^ ((c[15] ^ fw[i][j]) ? 16'h1021 : 16'h0000);
        return c;
    endfunction
`endif

    task automatic finish_words();
`ifdef ADS131_RX_CRC_EN
        fw[nw] = {crc_over(nw), 16'h0000};
        nw++;
`endif
    endtask

    task automatic set1(input logic [31:0] a);
        fw[0] = a; nw = 1; finish_words();
    endtask

    task automatic set5(input logic [31:0] a, b, c, d, e);
        fw[0] = a; fw[1] = b; fw[2] = c; fw[3] = d; fw[4] = e; nw = 5; finish_words();
    endtask

    task automatic spi_bit(input logic b, input bit coinc);
        bus.spi_miso = b;
        bus.spi_sclk = 1'b1;
        repeat (2) @(negedge clk);
        bus.spi_sclk = 1'b0;
        if (coinc) bus.spi_cs_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // last_bits: bits sent of the final word; abort_bit >= 0 pulses reset before that bit.
    task automatic send_frame(input int last_bits, input bit coinc, input int abort_bit);
        int k;
        k = 0;
        s_fv = n_fv; s_fe = n_fe; s_ce = n_ce;
        bus.spi_cs_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < nw; i++) begin
            for (int j = 31; j >= 0; j--) begin
                if (i == nw - 1 && (31 - j) >= last_bits) break;
                if (k == abort_bit) begin
                    reset_n = 1'b0;
                    repeat (2) @(negedge clk);
                    reset_n = 1'b1;
                    bus.spi_cs_n = 1'b1;
                    repeat (6) @(negedge clk);
                    return;
                end
                spi_bit(fw[i][j], coinc && (i == nw - 1) && ((31 - j) == last_bits - 1));
                k++;
            end
        end
        if (!coinc) bus.spi_cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic chk_strobes(input string tag, input int ev, input int ee);
        chk({tag, ".valid_pulses"}, 128'(n_fv - s_fv), 128'(ev));
        chk({tag, ".error_pulses"}, 128'(n_fe - s_fe), 128'(ee));
    endtask

    initial begin
        reset_n = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_miso = 1'b0;
        bus.adc_init_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.status", 128'(bus.status_word), 128'h0);
        chk("reset.ch_data", 128'(bus.ch_data), 128'h0);
        chk("reset.strobes", 128'({bus.frame_valid, bus.frame_error}), 128'h0);
        chk("reset.count", 128'(bus.frame_count), 128'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Pre-init single status word
        set1(32'h2200_0000);
        send_frame(32, 1'b0, -1);
        chk_strobes("t1", 1, 0);
        chk("t1.status", 128'(bus.status_word), 128'h2200_0000);
        chk("t1.ch_data", 128'(bus.ch_data), 128'h0);
        chk("t1.count", 128'(bus.frame_count), 128'd1);

        // Post-init full frame
        bus.adc_init_done = 1'b1;
        set5(32'h2200_0000, 32'h1234_5600, 32'hFFFF_FF00, 32'h8000_0000, 32'h0000_0100);
        send_frame(32, 1'b0, -1);
        chk_strobes("t2", 1, 0);
        chk("t2.ch_data", 128'(bus.ch_data), 128'h000001_800000_FFFFFF_123456);
        chk("t2.count", 128'(bus.frame_count), 128'd2);

        // Pre-init frame after data: status moves, channels hold
        bus.adc_init_done = 1'b0;
        set1(32'h1100_0000);
        send_frame(32, 1'b0, -1);
        chk_strobes("t2b", 1, 0);
        chk("t2b.status", 128'(bus.status_word), 128'h1100_0000);
        chk("t2b.ch_hold", 128'(bus.ch_data), 128'h000001_800000_FFFFFF_123456);

        // Short frame: 31 bits of the last word
        set1(32'h7700_0000);
        send_frame(31, 1'b0, -1);
        chk_strobes("t3a", 0, 1);
        chk("t3a.status_hold", 128'(bus.status_word), 128'h1100_0000);
        chk("t3a.count_hold", 128'(bus.frame_count), 128'd3);

        // Overlong frame: one word too many after init
        bus.adc_init_done = 1'b1;
        set5(32'h5500_0000, 32'h0101_0100, 32'h0202_0200, 32'h0303_0300, 32'h0404_0400);
        fw[nw] = 32'hDEAD_BEEF; nw++;
        send_frame(32, 1'b0, -1);
        chk_strobes("t3b", 0, 1);
        chk("t3b.ch_hold", 128'(bus.ch_data), 128'h000001_800000_FFFFFF_123456);
        chk("t3b.count_hold", 128'(bus.frame_count), 128'd3);

        // Reset at bit 70 of a 160-bit frame, then a good frame
        set5(32'h6600_0000, 32'h1111_1100, 32'h2222_2200, 32'h3333_3300, 32'h4444_4400);
        send_frame(32, 1'b0, 70);
        chk_strobes("t4.abort", 0, 0);
        chk("t4.status_reset", 128'(bus.status_word), 128'h0);
        chk("t4.count_reset", 128'(bus.frame_count), 128'h0);
        set5(32'h3300_0000, 32'hABCD_EF12, 32'h7FFF_FFAB, 32'h0000_0000, 32'h55AA_55CD);
        send_frame(32, 1'b0, -1);
        chk_strobes("t4.good", 1, 0);
        chk("t4.ch_data", 128'(bus.ch_data), 128'h55AA55_000000_7FFFFF_ABCDEF);
        chk("t4.count", 128'(bus.frame_count), 128'd1);

        // SCLK activity with CS high is ignored
        s_fv = n_fv; s_fe = n_fe;
        for (int i = 0; i < 10; i++) spi_bit(1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk_strobes("t5.idle_sclk", 0, 0);
        set5(32'h4400_0000, 32'h0000_10FF, 32'h1122_3344, 32'h9988_7766, 32'hF0F0_F0F0);
        send_frame(32, 1'b0, -1);
        chk_strobes("t5", 1, 0);
        chk("t5.status", 128'(bus.status_word), 128'h4400_0000);
        chk("t5.ch_data", 128'(bus.ch_data), 128'hF0F0F0_998877_112233_000010);
        chk("t5.count", 128'(bus.frame_count), 128'd2);

        // Final SCLK fall coincident with CS rise
        bus.adc_init_done = 1'b0;
        set1(32'h0000_0001);
        send_frame(32, 1'b1, -1);
        chk_strobes("t5.coinc", 1, 0);
        chk("t5.coinc_status", 128'(bus.status_word), 128'h0000_0001);
        chk("t5.coinc_count", 128'(bus.frame_count), 128'd3);

`ifdef ADS131_RX_CRC_EN
        bus.adc_init_done = 1'b1;
        set5(32'h2200_0000, 32'hCAFE_0100, 32'h0BAD_F000, 32'h1357_9B00, 32'h2468_AC00);
        send_frame(32, 1'b0, -1);
        chk_strobes("t6.good", 1, 0);
        chk("t6.ch_data", 128'(bus.ch_data), 128'h2468AC_13579B_0BADF0_CAFE01);
        set5(32'h2200_0000, 32'h1111_1100, 32'h2222_2200, 32'h3333_3300, 32'h4444_4400);
        fw[1][12] = ~fw[1][12];
        send_frame(32, 1'b0, -1);
        chk_strobes("t6.bad", 0, 0);
        chk("t6.crc_error_pulses", 128'(n_ce - s_ce), 128'd1);
        chk("t6.ch_hold", 128'(bus.ch_data), 128'h2468AC_13579B_0BADF0_CAFE01);
        chk("t6.count", 128'(bus.frame_count), 128'd4);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
